sprite_mem_arbiter: RTL

SPRITE_MEM_ARBITER -- requirements
Module: sprite_mem_arbiter

---
 rtl/sprite_mem_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/sprite_mem_arbiter.sv
// Sprite-memory arbiter: shares one synchronous single-port RAM between the
// barrier renderer (r0), the sprite renderer (r1) and the sprite loader (w).
// Grants are decided combinationally; the memory port is registered one
// cycle after the grant. Read data returns two cycles after the grant,
// tagged for its owner.
module sprite_mem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 9,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              r0_gnt,
  output logic              r1_gnt,
  output logic              w_gnt,
  output logic              r0_valid,
  output logic              r1_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  // Round-robin pointer between the sprite renderer and the loader.
  typedef enum logic {
    PTR_R1 = 1'b0,
    PTR_W  = 1'b1
  } rr_ptr_e;

  // Owner of the access sitting in the first tag stage.
  typedef enum logic [1:0] {
    TAG_NONE = 2'b00,
    TAG_R0   = 2'b01,
    TAG_R1   = 2'b10
  } owner_e;

  rr_ptr_e           rr_ptr_r;
  logic [CNT_W-1:0]  starve_cnt_r;
  logic              starved_s;
  logic              r0_gnt_s;
  logic              r1_gnt_s;
  logic              w_gnt_s;
  logic              grant_any_s;
  logic [ADDR_W-1:0] gnt_addr_s;
  owner_e            tag1_r;
  logic              r0_valid_r;
  logic              r1_valid_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              mem_we_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] rd_data_s;

  assign starved_s   = (starve_cnt_r == CNT_MAX);
  assign grant_any_s = r0_gnt_s | r1_gnt_s | w_gnt_s;

  // Pick at most one requester from the current requests, video phase,
  // round-robin pointer and starvation state; nothing is granted in reset.
  always_comb begin
    r0_gnt_s = 1'b0;
    r1_gnt_s = 1'b0;
    w_gnt_s  = 1'b0;
    if (reset) begin
      if (active) begin
        // Visible area: barrier renderer first, then r1/w share fairly.
        if (r0_req) begin
          r0_gnt_s = 1'b1;
        end else if (r1_req && (starved_s || !w_req || (rr_ptr_r == PTR_R1))) begin
          r1_gnt_s = 1'b1;
        end else if (w_req) begin
          w_gnt_s = 1'b1;
        end else begin
          w_gnt_s = 1'b0;
        end
      end else begin
        // Blanking: loader first, but a starved sprite renderer overrides.
        if (r1_req && starved_s) begin
          r1_gnt_s = 1'b1;
        end else if (w_req) begin
          w_gnt_s = 1'b1;
        end else if (r0_req) begin
          r0_gnt_s = 1'b1;
        end else if (r1_req) begin
          r1_gnt_s = 1'b1;
        end else begin
          r1_gnt_s = 1'b0;
        end
      end
    end else begin
      r0_gnt_s = 1'b0;
      r1_gnt_s = 1'b0;
      w_gnt_s  = 1'b0;
    end
  end

  // Select the address of the granted requester; hold the port otherwise.
  always_comb begin
    gnt_addr_s = mem_addr_r;
    case ({r0_gnt_s, r1_gnt_s, w_gnt_s})
      3'b100:  gnt_addr_s = r0_addr;
      3'b010:  gnt_addr_s = r1_addr;
      3'b001:  gnt_addr_s = w_addr;
      default: gnt_addr_s = mem_addr_r;
    endcase
  end

  // Read data is only meaningful while a valid is presented.
  always_comb begin
    if (r0_valid_r || r1_valid_r) begin
      rd_data_s = mem_rdata;
    end else begin
      rd_data_s = {DATA_W{1'b0}};
    end
  end

  // Round-robin pointer: after serving one of r1/w, favour the other one.
  // Only visible-area arbitration moves it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_r <= PTR_R1;
    end else if (active && r1_gnt_s) begin
      rr_ptr_r <= PTR_W;
    end else if (active && w_gnt_s) begin
      rr_ptr_r <= PTR_R1;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Starvation counter: counts cycles r1 waits, saturating at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (!r1_req || r1_gnt_s) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (!starved_s) begin
      starve_cnt_r <= starve_cnt_r + CNT_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Registered memory port: present the granted access one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_we_r    <= 1'b0;
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      mem_we_r <= w_gnt_s;
      if (grant_any_s) begin
        mem_addr_r <= gnt_addr_s;
      end else begin
        mem_addr_r <= mem_addr_r;
      end
      if (w_gnt_s) begin
        mem_wdata_r <= w_data;
      end else begin
        mem_wdata_r <= mem_wdata_r;
      end
    end
  end

  // Owner-tag pipeline: stage 1 aligns with the memory address, stage 2
  // with the returned read data. Writes carry no tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag1_r     <= TAG_NONE;
      r0_valid_r <= 1'b0;
      r1_valid_r <= 1'b0;
    end else begin
      if (r0_gnt_s) begin
        tag1_r <= TAG_R0;
      end else if (r1_gnt_s) begin
        tag1_r <= TAG_R1;
      end else begin
        tag1_r <= TAG_NONE;
      end
      r0_valid_r <= (tag1_r == TAG_R0);
      r1_valid_r <= (tag1_r == TAG_R1);
    end
  end

  assign r0_gnt    = r0_gnt_s;
  assign r1_gnt    = r1_gnt_s;
  assign w_gnt     = w_gnt_s;
  assign r0_valid  = r0_valid_r;
  assign r1_valid  = r1_valid_r;
  assign rd_data   = rd_data_s;
  assign mem_addr  = mem_addr_r;
  assign mem_we    = mem_we_r;
  assign mem_wdata = mem_wdata_r;

endmodule
